ifetch: RTL and testbench

Instruction fetch stage for the single-issue MIPS core. It holds the program counter, fetches one word per instruction from instruction memory over a request/acknowledge handshake, and presents the instruction and its opcode to the main decoder. It then waits for the downstream datapath to accept the instruction before computing the next PC from the branch, zero and jump results. It sits directly upstream of the main decoder and feeds it `op`.

---
 rtl/cpu_defs.sv | 19 +
 rtl/pc_next.sv | 31 +++
 rtl/ifetch.sv | 98 +++++++++
 tb/tb_ifetch.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared fetch FSM encoding, opcodes and default reset PC
package cpu_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-PC selection: jump, taken beq, or pc+4
module pc_next (
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] pcplus4,
  output logic [31:0] pc_nxt
);

  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;

  always_comb begin
    pcplus4   = pc + 32'd4;
    br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    br_target = pcplus4 + br_offset;
    // jump keeps the 256 MB region of the delay-slot address
    j_target  = {pcplus4[31:28], instr[25:0], 2'b00};
    if (jump) begin
      pc_nxt = j_target;
    end else if (branch && zero) begin
      pc_nxt = br_target;
    end else begin
      pc_nxt = pcplus4;
    end
  end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage: PC, imem handshake, instruction register
module ifetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] instret
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instret_q, instret_d;
  logic [31:0]  pc_nxt;
  logic         accept;

  pc_next u_pc_next (
    .pc      (pc_q),
    .instr   (instr_q),
    .branch  (branch),
    .zero    (zero),
    .jump    (jump),
    .pcplus4 (pcplus4),
    .pc_nxt  (pc_nxt)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instret_d   = instret_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        instr_valid = 1'b1;
        accept      = instr_ready;
        if (instr_ready) begin
          pc_d      = pc_nxt;
          instret_d = instret_q + 32'd1;
          state_d   = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign op        = instr_q[31:26];
  assign funct     = instr_q[5:0];
  assign instret   = instret_q;

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed scoreboard bench for ifetch
module tb_ifetch;

  localparam logic [31:0] RPC = 32'h0000_0040;
  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] instret;

  ifetch #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .instret     (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_err;
  int          n_checks;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] exp_instret;
  logic        hold_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] data, input int waits);
    logic [31:0] ea;
    logic [31:0] a0;
    wait_req();
    ea = 32'hxxxx_xxxx;
    if (exp_q.size() == 0) chk("sb_empty", 32'd0, 32'd1);
    else ea = exp_q.pop_front();
    a0 = imem_addr;
    chk("fetch_addr", imem_addr, ea);
    chk("fetch_pc", pc, ea);
    chk("fetch_valid_low", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      tick();
      chk("wait_req_high", {31'd0, imem_req}, 32'd1);
      chk("wait_addr_stable", imem_addr, a0);
      chk("wait_valid_low", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    m_instr    = data;
    m_pc       = ea;
    chk("valid_high", {31'd0, instr_valid}, 32'd1);
    chk("valid_req_low", {31'd0, imem_req}, 32'd0);
    chk("instr", instr, data);
    chk("op", {26'd0, op}, {26'd0, data[31:26]});
    chk("funct", {26'd0, funct}, {26'd0, data[5:0]});
    chk("pcplus4", pcplus4, ea + 32'd4);
  endtask

  task automatic accept(input logic b, input logic z, input logic j);
    logic [31:0] p4;
    logic [31:0] nxt;
    p4 = m_pc + 32'd4;
    if (j) nxt = {p4[31:28], m_instr[25:0], 2'b00};
    else if (b && z) nxt = p4 + {{14{m_instr[15]}}, m_instr[15:0], 2'b00};
    else nxt = p4;
    exp_q.push_back(nxt);
    instr_ready = 1'b1;
    branch      = b;
    zero        = z;
    jump        = j;
    tick();
    instr_ready = hold_ready;
    branch      = $urandom;
    zero        = $urandom;
    jump        = $urandom;
    exp_instret = exp_instret + 32'd1;
    chk("instret", instret, exp_instret);
    chk("after_accept_req", {31'd0, imem_req}, 32'd1);
    chk("after_accept_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_err       = 0;
    n_checks    = 0;
    exp_instret = 0;
    hold_ready  = 1'b0;
    reset_n     = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    instr_ready = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    jump        = 1'b0;
    #12;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instret", instret, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("release_req_low", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    exp_q.push_back(RPC);

    // zero-wait memory, downstream always ready
    hold_ready  = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fetch(NOP, 0);
      accept(1'b0, 1'b0, 1'b0);
    end
    chk("instret_3", instret, 32'd3);
    hold_ready  = 1'b0;
    instr_ready = 1'b0;

    // 3-cycle memory wait; the fetched word is a j to 0x100
    fetch(32'h0800_0040, 3);
    accept(1'b0, 1'b0, 1'b1);
    fetch(32'h1000_FFFF, 0);
    accept(1'b1, 1'b1, 1'b0);
    fetch(32'h1000_FFFF, 0);
    accept(1'b1, 1'b0, 1'b0);
    fetch(32'h0BFF_FFFF, 0);
    accept(1'b0, 1'b0, 1'b1);
    fetch(NOP, 0);
    accept(1'b0, 1'b0, 1'b0);
    fetch(32'h0800_0010, 0);
    accept(1'b1, 1'b1, 1'b1);

    // stall in VALID with noisy control inputs and a stray ack
    fetch(32'h8C01_0004, 0);
    for (int i = 0; i < 5; i++) begin
      instr_ready = 1'b0;
      branch      = i[0];
      zero        = i[1];
      jump        = ~i[0];
      imem_ack    = (i == 2);
      imem_rdata  = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      chk("hold_instr", instr, m_instr);
      chk("hold_pc", pc, m_pc);
      chk("hold_op", {26'd0, op}, {26'd0, m_instr[31:26]});
      chk("hold_instret", instret, exp_instret);
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    end
    accept(1'b0, 1'b0, 1'b0);

    // reset during FETCH, then a late ack while in IDLE
    chk("pre_reset_pc", pc, 32'h1000_0044);
    exp_q.delete();
    reset_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", pc, RPC);
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_instret", instret, 32'd0);
    @(negedge clk);
    reset_n    = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("idle_req_low", {31'd0, imem_req}, 32'd0);
    tick();
    imem_ack = 1'b0;
    chk("late_ack_req", {31'd0, imem_req}, 32'd1);
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_ack_instr", instr, 32'd0);
    chk("late_ack_pc", pc, RPC);
    exp_instret = 0;
    exp_q.push_back(RPC);
    fetch(NOP, 1);
    accept(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
